dpi_trace_sched: RTL and testbench

//  Capture scheduler in front of the DPI trace writer. Merges NCH record channels
//  (rx/tx data, k-flags, valids per lane) into one timestamped record stream via

---
 rtl/dpi_trace_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_dpi_trace_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_trace_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dpi_trace_sched
//  Purpose  : Capture scheduler in front of the DPI trace writer. Merges NCH
//             record channels into one timestamped record stream using
//             round-robin arbitration. An arm/trigger/length FSM limits capture
//             to a bounded window, so the simulation log holds only that window.
//  Ports    : clk, rst (async, active-high)
//             arm_i / abort_i / trig_i / cap_len_i   capture control
//             ch_valid / ch_data / ch_ready          per-channel record inputs
//             out_valid / out_ready / out_time /
//             out_type / out_data                    record stream to writer
//             state_o / rec_cnt / done               capture status
//  Revision : 1.0  initial release
// ============================================================================
module dpi_trace_sched #(
    parameter int NCH = 6,
    parameter int DW  = 544,
    parameter int TW  = 64,
    parameter int CW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              trig_i,
    input  logic [CW-1:0]     cap_len_i,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [NCH-1:0]    ch_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TW-1:0]     out_time,
    output logic [5:0]        out_type,
    output logic [DW-1:0]     out_data,
    output logic [1:0]        state_o,
    output logic [CW-1:0]     rec_cnt,
    output logic              done
);

    localparam int                C_PW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [C_PW:0]     C_NCH     = (C_PW + 1)'(NCH);
    localparam logic [C_PW-1:0]   C_LAST    = C_PW'(NCH - 1);

    localparam logic [1:0]        C_IDLE    = 2'd0;
    localparam logic [1:0]        C_ARMED   = 2'd1;
    localparam logic [1:0]        C_CAPTURE = 2'd2;
    localparam logic [1:0]        C_DONE    = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [CW-1:0]   r_len;
    logic [TW-1:0]   r_ts;
    logic [CW-1:0]   r_rec_cnt;
    logic [C_PW-1:0] r_ptr;
    logic            r_out_valid;
    logic [TW-1:0]   r_out_time;
    logic [5:0]      r_out_type;
    logic [DW-1:0]   r_out_data;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic             w_arm_load;
    logic             w_grant;
    logic [2*NCH-1:0] w_vv;
    logic [NCH-1:0]   w_rot;
    logic [C_PW:0]    w_off;
    logic [C_PW:0]    w_sum;
    logic [C_PW-1:0]  w_win;
    logic [C_PW-1:0]  w_ptr_nxt;

    // An arm is honoured only from IDLE or DONE, and abort always wins.
    assign w_arm_load = arm_i && !abort_i && ((r_state == C_IDLE) || (r_state == C_DONE));

    // ------------------------------------------------------------------
    // Round-robin pick: rotate the valid vector so that the pointer
    // channel sits at bit 0. The lowest set bit gives the offset from the
    // pointer, and adding the pointer back (mod NCH) gives the winner.
    // ------------------------------------------------------------------
    assign w_vv = {ch_valid, ch_valid};

    always_comb begin
        w_rot = w_vv[r_ptr +: NCH];
        w_off = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (C_PW + 1)'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + w_off;
        w_win = (w_sum >= C_NCH) ? C_PW'(w_sum - C_NCH) : C_PW'(w_sum);
    end

    assign w_ptr_nxt = (w_win == C_LAST) ? '0 : (w_win + C_PW'(1));

    // A grant needs room in the output stage (empty or draining this cycle)
    // and budget left in the window. It is suppressed in an abort cycle,
    // because the output stage is flushed then and the record would be lost.
    assign w_grant = (r_state == C_CAPTURE) && !abort_i &&
                     (!r_out_valid || out_ready) &&
                     (r_rec_cnt < r_len) && (|ch_valid);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = C_IDLE;
        end else begin
            case (r_state)
                C_IDLE, C_DONE: begin
                    if (arm_i) begin
                        // A zero-length window finishes immediately.
                        w_state_nxt = (cap_len_i == '0) ? C_DONE : C_ARMED;
                    end
                end
                C_ARMED: begin
                    if (trig_i) begin
                        w_state_nxt = C_CAPTURE;
                    end
                end
                C_CAPTURE: begin
                    if (w_grant && ((r_rec_cnt + CW'(1)) == r_len)) begin
                        w_state_nxt = C_DONE;
                    end
                end
                default: w_state_nxt = C_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Outside CAPTURE every channel is drained and the data
    // is discarded, so upstream never stalls while the window is closed.
    // ------------------------------------------------------------------
    always_comb begin
        ch_ready = '1;
        if (r_state == C_CAPTURE) begin
            ch_ready = w_grant ? (NCH'(1) << w_win) : '0;
        end
    end

    assign state_o   = r_state;
    assign done      = (r_state == C_DONE) && !r_out_valid;
    assign rec_cnt   = r_rec_cnt;
    assign out_valid = r_out_valid;
    assign out_time  = r_out_time;
    assign out_type  = r_out_type;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Window length, timestamp, record counter and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= '0;
            r_ts      <= '0;
            r_rec_cnt <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_arm_load) begin
                r_len     <= cap_len_i;
                r_ts      <= '0;
                r_rec_cnt <= '0;
            end else begin
                // Timestamp runs in every state but IDLE and sticks at all-ones.
                if ((r_state != C_IDLE) && (r_ts != '1)) begin
                    r_ts <= r_ts + TW'(1);
                end
                if (w_grant) begin
                    r_rec_cnt <= r_rec_cnt + CW'(1);
                end
            end
            if (w_grant) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one register slot. A load in the same cycle as a drain
    // keeps the stream at one record per cycle. Payload fields hold their
    // last value after a drain; only the valid flag is cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_time  <= '0;
            r_out_type  <= '0;
            r_out_data  <= '0;
        end else begin
            if (abort_i) begin
                r_out_valid <= 1'b0;
            end else if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_time  <= r_ts;
                r_out_type  <= 6'(w_win);
                r_out_data  <= ch_data[w_win*DW +: DW];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpi_trace_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpi_trace_sched
//  Purpose  : Self-checking bench for dpi_trace_sched. A behavioural model of
//             the capture window, arbitration and output register is compared
//             against the DUT on every falling edge, and directed scenarios
//             pin the model with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dpi_trace_sched;

    localparam int NCH = 6;
    localparam int DW  = 544;
    localparam int TW  = 64;
    localparam int CW  = 32;

    localparam int ST_IDLE = 0;
    localparam int ST_ARM  = 1;
    localparam int ST_CAP  = 2;
    localparam int ST_DONE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              trig_i = 1'b0;
    logic [CW-1:0]     cap_len_i = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [TW-1:0]     out_time;
    logic [5:0]        out_type;
    logic [DW-1:0]     out_data;
    logic [1:0]        state_o;
    logic [CW-1:0]     rec_cnt;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    int            q_type[$];
    logic [TW-1:0] q_time[$];

    dpi_trace_sched #(.NCH(NCH), .DW(DW), .TW(TW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm_i     (arm_i),
        .abort_i   (abort_i),
        .trig_i    (trig_i),
        .cap_len_i (cap_len_i),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .ch_ready  (ch_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_time  (out_time),
        .out_type  (out_type),
        .out_data  (out_data),
        .state_o   (state_o),
        .rec_cnt   (rec_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int            m_st;
    logic [CW-1:0] m_len;
    logic [TW-1:0] m_ts;
    logic [CW-1:0] m_cnt;
    int            m_ptr;
    logic          m_ov;
    logic [TW-1:0] m_ot;
    int            m_oty;
    logic [DW-1:0] m_od;

    // First valid channel at or after pointer p, circularly; -1 if none.
    function automatic int rr_pick(input logic [NCH-1:0] v, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (v[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    function automatic int m_win();
        return rr_pick(ch_valid, m_ptr);
    endfunction

    function automatic logic m_grant();
        return (m_st == ST_CAP) && !abort_i && (!m_ov || out_ready) &&
               (m_cnt < m_len) && (m_win() >= 0);
    endfunction

    function automatic logic m_arming();
        return arm_i && !abort_i && (m_st == ST_IDLE || m_st == ST_DONE);
    endfunction

    function automatic logic [NCH-1:0] m_ready();
        if (m_st != ST_CAP) return '1;
        if (m_grant()) return NCH'(1) << m_win();
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st  <= ST_IDLE;
            m_len <= '0;
            m_ts  <= '0;
            m_cnt <= '0;
            m_ptr <= 0;
            m_ov  <= 1'b0;
            m_ot  <= '0;
            m_oty <= 0;
            m_od  <= '0;
        end else begin
            if (abort_i) begin
                m_ov <= 1'b0;
            end else if (m_grant()) begin
                m_ov  <= 1'b1;
                m_ot  <= m_ts;
                m_oty <= m_win();
                m_od  <= ch_data[m_win()*DW +: DW];
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end

            if (m_arming()) begin
                m_len <= cap_len_i;
                m_ts  <= '0;
                m_cnt <= '0;
            end else begin
                if (m_st != ST_IDLE && m_ts != '1) m_ts <= m_ts + 1;
                if (m_grant()) m_cnt <= m_cnt + 1;
            end

            if (m_grant()) m_ptr <= (m_win() + 1) % NCH;

            if (abort_i)                                            m_st <= ST_IDLE;
            else if (m_arming())                                    m_st <= (cap_len_i == 0) ? ST_DONE : ST_ARM;
            else if (m_st == ST_ARM && trig_i)                      m_st <= ST_CAP;
            else if (m_st == ST_CAP && m_grant() && m_cnt + 1 == m_len) m_st <= ST_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Cycle compare against the model, plus a log of drained records
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("state_o",   state_o,   m_st);
            chk("out_valid", out_valid, m_ov);
            chk("rec_cnt",   rec_cnt,   m_cnt);
            chk("done",      done,      (m_st == ST_DONE) && !m_ov);
            chk("ch_ready",  ch_ready,  m_ready());
            chk("out_time",  out_time,  m_ot);
            chk("out_type",  out_type,  m_oty);
            chk("out_data",  out_data,  m_od);
            if (out_valid && out_ready) begin
                q_type.push_back(int'(out_type));
                q_time.push_back(out_time);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH*DW/32; i++) ch_data[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic arm_trig(input int len);
        arm_i = 1'b1; cap_len_i = CW'(len);
        cyc(1);
        arm_i = 1'b0;
        trig_i = 1'b1;
        cyc(1);
        trig_i = 1'b0;
    endtask

    initial begin
        int exp1[3];
        exp1 = '{0, 2, 0};

        // Reset state
        do_reset();
        cyc(1);
        chk("rst_state", state_o, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_ready", ch_ready, 6'h3f);

        // 1: two channels, len 3 -> 0,2,0
        q_type.delete(); q_time.delete();
        out_ready = 1'b1; ch_valid = 6'b000101;
        arm_trig(3);
        cyc(8);
        chk("t1_count", q_type.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_type.size()) chk("t1_type", q_type[i], exp1[i]);
            else                   chk("t1_missing", 1, 0);
        end
        chk("t1_reccnt", rec_cnt, 3);
        chk("t1_state", state_o, ST_DONE);
        chk("t1_done", done, 1);

        // 2: all channels, len 12 -> 0..5 twice, times contiguous
        do_reset();
        q_type.delete(); q_time.delete();
        ch_valid = '1; out_ready = 1'b1;
        arm_trig(12);
        cyc(16);
        chk("t2_count", q_type.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < q_type.size()) chk("t2_type", q_type[i], i % NCH);
            if (i > 0 && i < q_time.size()) chk("t2_time_step", q_time[i] - q_time[i-1], 1);
        end

        // 3: backpressure on the output holds the record and stalls ch1
        do_reset();
        q_type.delete(); q_time.delete();
        ch_valid = 6'b000010; out_ready = 1'b1;
        arm_trig(20);
        cyc(2);
        out_ready = 1'b0;
        cyc(5);
        chk("t3_ready_low", ch_ready, 0);
        chk("t3_held", out_valid, 1);
        out_ready = 1'b1;
        cyc(3);
        chk("t3_reccnt", rec_cnt, 5);

        // 4: trig in the arm cycle ignored; later trig starts capture
        do_reset();
        q_type.delete(); q_time.delete();
        ch_valid = 6'b100000; out_ready = 1'b1;
        arm_i = 1'b1; trig_i = 1'b1; cap_len_i = CW'(5);
        cyc(1);
        arm_i = 1'b0; trig_i = 1'b0;
        cyc(2);
        chk("t4_still_armed", state_o, ST_ARM);
        trig_i = 1'b1;
        cyc(1);
        trig_i = 1'b0;
        chk("t4_capture", state_o, ST_CAP);
        cyc(2);
        if (q_time.size() > 0) chk("t4_first_time", q_time[0], 3);
        else                   chk("t4_no_record", 1, 0);

        // 5: abort with a record in flight, then a zero-length arm
        chk("t5_pre_ovalid", out_valid, 1);
        abort_i = 1'b1;
        cyc(1);
        abort_i = 1'b0;
        chk("t5_idle", state_o, ST_IDLE);
        chk("t5_ovalid", out_valid, 0);
        chk("t5_ready", ch_ready, 6'h3f);
        arm_i = 1'b1; cap_len_i = '0;
        cyc(1);
        arm_i = 1'b0;
        chk("t5_done_state", state_o, ST_DONE);
        chk("t5_done", done, 1);

        // Random windows
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            arm_i     = ($urandom_range(0, 39) == 0);
            trig_i    = ($urandom_range(0, 7) == 0);
            abort_i   = ($urandom_range(0, 149) == 0);
            cap_len_i = CW'($urandom_range(0, 10));
            ch_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        arm_i = 1'b0; trig_i = 1'b0; abort_i = 1'b0;

        // 6: asynchronous reset mid-capture
        ch_valid = '1; out_ready = 1'b1;
        abort_i = 1'b1; cyc(1); abort_i = 1'b0;
        arm_trig(50);
        cyc(5);
        #2 rst = 1'b1;
        #1;
        chk("t6_state", state_o, 0);
        chk("t6_ovalid", out_valid, 0);
        chk("t6_time", out_time, 0);
        chk("t6_type", out_type, 0);
        chk("t6_data", out_data, 0);
        chk("t6_reccnt", rec_cnt, 0);
        chk("t6_ready", ch_ready, 6'h3f);
        chk("t6_done", done, 0);
        cyc(1);
        rst = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
